// File: rtl/gray2rgb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gray2rgb_pkg
//  Purpose  : Shared types and helpers for the gray-to-RGB stream back-end.
//             Holds the frame FSM state encoding, the FIFO pixel entry and
//             the luminance normalisation function.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package gray2rgb_pkg;

   localparam int unsigned c_LUM_W = 15;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   // One FIFO entry: replicated channels plus the position tags computed
   // when the luminance word was accepted.
   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
      logic       sol;
      logic       eol;
      logic       sof;
      logic       eof;
   } pixel_t;

   // Drop the weight-sum scaling and clamp to the 8-bit range. Truncation,
   // no rounding.
   function automatic logic [7:0] sat_norm(input logic [c_LUM_W-1:0] lum,
                                           input int unsigned         shift);
      logic [c_LUM_W-1:0] w_shifted;
      w_shifted = lum >> shift;
      return (w_shifted > c_LUM_W'(255)) ? 8'hFF : w_shifted[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/gray2rgb_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : gray2rgb_skid_fifo
//  Purpose  : Two-entry valid/ready output buffer. Slot 0 is always the head,
//             so the output data is a plain register and stays stable while
//             the consumer stalls.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low reset (flushes buffer)
//             push_i     - write din_i this cycle (ignored when full)
//             din_i      - entry to write
//             count_o    - current occupancy (0..2)
//             out_valid_o- head entry is valid
//             out_ready_i- consumer takes the head entry
//             dout_o     - head entry
//  Revision : 1.0  initial release
// ============================================================================
module gray2rgb_skid_fifo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [1:0]       count_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] slot0_q;
   logic [WIDTH-1:0] slot1_q;
   logic [1:0]       count_q;
   logic             w_push;
   logic             w_pop;

   assign w_push      = push_i && (count_q != 2'd2);
   assign w_pop       = (count_q != 2'd0) && out_ready_i;
   assign out_valid_o = (count_q != 2'd0);
   assign count_o     = count_q;
   assign dout_o      = slot0_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (count_q == 2'd0) slot0_q <= din_i;
               else                 slot1_q <= din_i;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               slot0_q <= slot1_q;
               count_q <= count_q - 2'd1;
            end
            // Push and pop together only happens with one entry held
            // (pop needs >=1, push needs <2): the new word becomes head.
            2'b11: begin
               slot0_q <= din_i;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/gray_to_rgb_stream.sv
`default_nettype none
// ============================================================================
//  Module   : gray_to_rgb_stream
//  Purpose  : Normalises 15-bit weighted luminance sums to 8-bit gray,
//             replicates onto R/G/B, tags line/frame boundaries and buffers
//             the result behind a 2-entry valid/ready FIFO.
//  Option   : GRAY2RGB_THRESH_EN adds an 8-bit thresh input; each pixel is
//             then forced to 255 (g >= thresh) or 0 (binary output).
//  Ports    : clk, rst_n        - clock / async active-low reset
//             start             - begins a frame when idle
//             in_valid/in_ready - luminance handshake, in_lum data
//             out_valid/out_ready - pixel handshake
//             out_red/green/blue - pixel channels
//             out_sol/eol/sof/eof - line / frame position tags
//             busy              - frame in progress
//             frame_done        - one-cycle pulse after the last pixel left
//             thresh            - (option only) binarisation threshold
//  Revision : 1.0  initial release
// ============================================================================
module gray_to_rgb_stream
   import gray2rgb_pkg::*;
#(
   parameter int unsigned IMG_W      = 640,
   parameter int unsigned IMG_H      = 480,
   parameter int unsigned NORM_SHIFT = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [c_LUM_W-1:0] in_lum,
`ifdef GRAY2RGB_THRESH_EN
   input  logic [7:0]         thresh,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_red,
   output logic [7:0]         out_green,
   output logic [7:0]         out_blue,
   output logic               out_sol,
   output logic               out_eol,
   output logic               out_sof,
   output logic               out_eof,
   output logic               busy,
   output logic               frame_done
);

   localparam int unsigned c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
   localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);

   state_t             state_q;
   logic [c_COL_W-1:0] col_q, col_d;
   logic [c_ROW_W-1:0] row_q, row_d;
   logic               frame_done_q;

   logic               w_accept;
   logic               w_col_last;
   logic               w_row_last;
   logic [7:0]         w_gray;
   logic [7:0]         w_chan;
   logic [1:0]         w_fifo_count;
   pixel_t             w_pix_in;
   pixel_t             w_pix_out;

   // ---------------------------------------------------------------- input
   assign in_ready   = (state_q == ACTIVE) && (w_fifo_count < 2'd2);
   assign w_accept   = in_valid && in_ready;
   assign w_col_last = (col_q == c_COL_LAST);
   assign w_row_last = (row_q == c_ROW_LAST);

   assign w_gray = sat_norm(in_lum, NORM_SHIFT);
`ifdef GRAY2RGB_THRESH_EN
   assign w_chan = (w_gray >= thresh) ? 8'hFF : 8'h00;
`else
   assign w_chan = w_gray;
`endif

   always_comb begin
      w_pix_in       = '0;
      w_pix_in.red   = w_chan;
      w_pix_in.green = w_chan;
      w_pix_in.blue  = w_chan;
      w_pix_in.sol   = (col_q == '0);
      w_pix_in.eol   = w_col_last;
      w_pix_in.sof   = (col_q == '0) && (row_q == '0);
      w_pix_in.eof   = w_col_last && w_row_last;
   end

   // Raster position after the current accept; wraps to (0,0) at frame end.
   always_comb begin
      col_d = col_q + c_COL_W'(1);
      row_d = row_q;
      if (w_col_last) begin
         col_d = '0;
         row_d = w_row_last ? '0 : row_q + c_ROW_W'(1);
      end
   end

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= ACTIVE;
                  col_q   <= '0;
                  row_q   <= '0;
               end
            end
            ACTIVE: begin
               if (w_accept) begin
                  col_q <= col_d;
                  row_q <= row_d;
                  if (w_col_last && w_row_last) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_fifo_count == 2'd0) begin
                  state_q      <= DONE;
                  frame_done_q <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = (state_q != IDLE);
   assign frame_done = frame_done_q;

   // --------------------------------------------------------------- output
   gray2rgb_skid_fifo #(
      .WIDTH ($bits(pixel_t))
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (w_accept),
      .din_i       (w_pix_in),
      .count_o     (w_fifo_count),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .dout_o      (w_pix_out)
   );

   assign out_red   = w_pix_out.red;
   assign out_green = w_pix_out.green;
   assign out_blue  = w_pix_out.blue;
   assign out_sol   = w_pix_out.sol;
   assign out_eol   = w_pix_out.eol;
   assign out_sof   = w_pix_out.sof;
   assign out_eof   = w_pix_out.eof;

endmodule
`default_nettype wire

// File: tb/tb_gray_to_rgb_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_to_rgb_stream
//  Purpose  : Self-checking bench for gray_to_rgb_stream (4x2 frames).
//             A queue-based pixel model is compared against the DUT on every
//             falling edge; directed literal checks pin the model.
//  Option   : honours GRAY2RGB_THRESH_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gray_to_rgb_stream;

   localparam int W = 4;
   localparam int H = 2;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        start     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic [14:0] in_lum    = '0;
`ifdef GRAY2RGB_THRESH_EN
   logic [7:0]  thresh    = 8'd128;
`endif
   logic        in_ready, out_valid, out_sol, out_eol, out_sof, out_eof;
   logic        busy, frame_done;
   logic [7:0]  out_red, out_green, out_blue;

   int total = 0;
   int bad   = 0;

   gray_to_rgb_stream #(.IMG_W(W), .IMG_H(H), .NORM_SHIFT(7)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_lum(in_lum),
`ifdef GRAY2RGB_THRESH_EN
      .thresh(thresh),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
      .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof), .out_eof(out_eof),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   typedef struct {
      int red;
      bit sol, eol, sof, eof;
   } exp_t;

   exp_t mq[$];
   int   m_state = 0;   // 0 idle, 1 taking pixels, 2 waiting for empty, 3 done pulse
   int   m_idx   = 0;   // pixels accepted in the current frame

   function automatic exp_t mk(input int lum, input int thr, input int idx);
      exp_t e;
      int g;
      g = lum / 128;
      if (g > 255) g = 255;
`ifdef GRAY2RGB_THRESH_EN
      g = (g >= thr) ? 255 : 0;
`endif
      e.red = g;
      e.sol = (idx % W) == 0;
      e.eol = (idx % W) == W - 1;
      e.sof = idx == 0;
      e.eof = idx == W * H - 1;
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_state = 0;
         m_idx   = 0;
      end else begin
         int sz0;
         int thr;
         bit acc;
         sz0 = mq.size();
`ifdef GRAY2RGB_THRESH_EN
         thr = int'(thresh);
`else
         thr = 0;
`endif
         acc = in_valid && (m_state == 1) && (sz0 < 2);
         if (sz0 != 0 && out_ready) void'(mq.pop_front());
         case (m_state)
            0: if (start) begin m_state = 1; m_idx = 0; end
            1: if (acc) begin
                  mq.push_back(mk(int'(in_lum), thr, m_idx));
                  m_idx++;
                  if (m_idx == W * H) m_state = 2;
               end
            2: if (sz0 == 0) m_state = 3;
            default: m_state = 0;
         endcase
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      chk("in_ready",   in_ready,   (m_state == 1 && mq.size() < 2) ? 1 : 0);
      chk("out_valid",  out_valid,  (mq.size() != 0) ? 1 : 0);
      chk("busy",       busy,       (m_state != 0) ? 1 : 0);
      chk("frame_done", frame_done, (m_state == 3) ? 1 : 0);
      if (mq.size() != 0) begin
         chk("red",   out_red,   mq[0].red);
         chk("green", out_green, mq[0].red);
         chk("blue",  out_blue,  mq[0].red);
         chk("sol",   out_sol,   mq[0].sol);
         chk("eol",   out_eol,   mq[0].eol);
         chk("sof",   out_sof,   mq[0].sof);
         chk("eof",   out_eof,   mq[0].eof);
      end
   end

   // Record every transferred pixel's red channel.
   int seen[$];
   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) seen.push_back(int'(out_red));
   end

   // ------------------------------------------------------------- stimulus
   int f1_lum[8]  = '{12800, 0, 32767, 32640, 256, 1000, 16383, 127};
   int bp_lum[8]  = '{1280, 2560, 3840, 5120, 6400, 7680, 8960, 10240};
   int f1_sol[8]  = '{1, 0, 0, 0, 1, 0, 0, 0};
   int f1_eol[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
   int f1_sof[8]  = '{1, 0, 0, 0, 0, 0, 0, 0};
   int f1_eof[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
`ifdef GRAY2RGB_THRESH_EN
   int f1_red[8]  = '{0, 0, 255, 255, 0, 0, 0, 0};       // thresh = 128
   int bp_red[8]  = '{255, 255, 255, 255, 255, 255, 255, 255}; // thresh = 0
`else
   int f1_red[8]  = '{100, 0, 255, 255, 2, 7, 127, 0};
   int bp_red[8]  = '{10, 20, 30, 40, 50, 60, 70, 80};
`endif

   int k        = 0;
   int accepts  = 0;

   task automatic send(input int lum);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_lum   = 15'(lum);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int pulses;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (frame_done) pulses++;
      end
      chk("frame_done_pulses", pulses, 1);
      chk("busy_after_done", busy, 0);
   endtask

   task automatic drive_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         bit acc;
         acc = in_valid && in_ready;
         @(negedge clk);
         if (acc) begin
            k++;
            accepts++;
            if (k < 8) in_lum = 15'(bp_lum[k]);
            else       in_valid = 1'b0;
         end
         if (!out_ready && out_valid) chk("hold_red", out_red, bp_red[0]);
      end
   endtask

   initial begin
      // ---- reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid",  out_valid,  0);
      chk("rst_in_ready",   in_ready,   0);
      chk("rst_busy",       busy,       0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_out_red",    out_red,    0);
      chk("rst_out_sof",    out_sof,    0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- frame 1: normalisation and flags, no back-pressure
      out_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         send(f1_lum[i]);
         chk("f1_red", out_red, f1_red[i]);
         chk("f1_sol", out_sol, f1_sol[i]);
         chk("f1_eol", out_eol, f1_eol[i]);
         chk("f1_sof", out_sof, f1_sof[i]);
         chk("f1_eof", out_eof, f1_eof[i]);
      end
      wait_done();

      // ---- input while idle is refused
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_in_ready",  in_ready,  0);
         chk("idle_out_valid", out_valid, 0);
      end
      in_valid = 1'b0;

      // ---- back-pressure, plus an ignored start mid-frame
`ifdef GRAY2RGB_THRESH_EN
      thresh = 8'd0;
`endif
      seen.delete();
      out_ready = 1'b0;
      pulse_start();
      k = 0;
      accepts = 0;
      in_lum = 15'(bp_lum[0]);
      in_valid = 1'b1;
      drive_cycles(6);
      chk("bp_accepts", accepts, 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_red", out_red, bp_red[0]);
      out_ready = 1'b1;
      start = 1'b1;
      drive_cycles(1);
      start = 1'b0;
      for (int t = 0; t < 40 && k < 8; t++) drive_cycles(1);
      chk("bp_all_accepted", k, 8);
      wait_done();
      chk("bp_seen_count", seen.size(), 8);
      for (int i = 0; i < 8 && i < seen.size(); i++) chk("bp_order", seen[i], bp_red[i]);

      // ---- reset mid-frame with two pixels buffered
      pulse_start();
      send(bp_lum[0]);
      send(bp_lum[1]);
      out_ready = 1'b0;
      send(bp_lum[2]);
      chk("pre_rst_out_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_busy",      busy,      0);
      repeat (3) @(negedge clk);
      chk("rst_no_frame_done", frame_done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      pulse_start();
      send(bp_lum[3]);
      chk("restart_sof", out_sof, 1);
      chk("restart_sol", out_sol, 1);
      for (int i = 4; i < 11; i++) send(bp_lum[i % 8]);
      wait_done();

`ifdef GRAY2RGB_THRESH_EN
      // ---- binarisation, threshold sampled per pixel
      thresh = 8'd128;
      pulse_start();
      send(16384);
      chk("thr_128_at", out_red, 255);
      send(16256);
      chk("thr_127_below", out_red, 0);
      thresh = 8'd0;
      send(0);
      chk("thr_zero", out_red, 255);
      for (int i = 3; i < 8; i++) send(1280);
      wait_done();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
